// File: rtl/regfile_writeback_arbiter_if.sv
// Register-file write-port bundle: ALU writeback, MDU valid/ready result path,
// issue-time scoreboard marking, and the registered write port itself.
interface regfile_writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_wb_en;
  logic [ADDR_W-1:0] alu_wb_reg;
  logic [DATA_W-1:0] alu_wb_data;

  // MDU handshake: a result transfers on any rising edge where mdu_valid and
  // mdu_ready are both high; mdu_valid may drop without a transfer.
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_reg;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;

  logic              issue_en;
  logic [ADDR_W-1:0] issue_reg;
  logic [31:0]       pending;

  logic              regWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              wb_src;

  modport master (
    output alu_wb_en, alu_wb_reg, alu_wb_data,
    output mdu_valid, mdu_reg, mdu_data,
    input  mdu_ready,
    output issue_en, issue_reg,
    input  pending,
    input  regWrite, WriteRegister, WriteData, wb_src
  );

  modport slave (
    input  alu_wb_en, alu_wb_reg, alu_wb_data,
    input  mdu_valid, mdu_reg, mdu_data,
    output mdu_ready,
    input  issue_en, issue_reg,
    output pending,
    output regWrite, WriteRegister, WriteData, wb_src
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Single register-file write port shared by the never-stalled ALU writeback and
// a FIFO-buffered MDU result stream, plus the MDU pending-destination scoreboard.
module regfile_writeback_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_writeback_arbiter_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_reg  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;

  logic              we_q, src_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       pend_q;

  logic              we_nxt, src_nxt;
  logic [ADDR_W-1:0] wreg_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [31:0]       pend_nxt;

  logic ready, accept, push, pop, alu_sel;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even on an edge where it also pops.
  assign ready     = !reset && (count < DEPTH_C);
  assign accept    = bus.mdu_valid && ready;
  assign push      = accept && (bus.mdu_reg != '0);
  assign alu_sel   = bus.alu_wb_en && (bus.alu_wb_reg != '0);
  assign pop       = !reset && !alu_sel && (count != '0);
  assign head_reg  = fifo_reg[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    we_nxt    = 1'b0;
    wreg_nxt  = wreg_q;
    wdata_nxt = wdata_q;
    src_nxt   = src_q;
    if (alu_sel) begin
      we_nxt    = 1'b1;
      wreg_nxt  = bus.alu_wb_reg;
      wdata_nxt = bus.alu_wb_data;
      src_nxt   = 1'b0;
    end else if (pop) begin
      we_nxt    = 1'b1;
      wreg_nxt  = head_reg;
      wdata_nxt = head_data;
      src_nxt   = 1'b1;
    end
  end

  // Retire-clear first, then issue-set, so a new issue to the retiring register wins.
  always_comb begin
    pend_nxt = pend_q;
    if (pop) begin
      pend_nxt[head_reg] = 1'b0;
    end
    if (bus.issue_en && (bus.issue_reg != '0)) begin
      pend_nxt[bus.issue_reg] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count_nxt;
      we_q    <= we_nxt;
      wreg_q  <= wreg_nxt;
      wdata_q <= wdata_nxt;
      src_q   <= src_nxt;
      pend_q  <= pend_nxt;
    end
  end

  // Storage needs no reset: only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= bus.mdu_reg;
      fifo_data[wr_ptr] <= bus.mdu_data;
    end
  end

  assign bus.mdu_ready     = ready;
  assign bus.pending       = pend_q;
  assign bus.regWrite      = we_q;
  assign bus.WriteRegister = wreg_q;
  assign bus.WriteData     = wdata_q;
  assign bus.wb_src        = src_q;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomized and directed bench for regfile_writeback_arbiter with a queue-based
// reference model feeding a per-cycle expected-state scoreboard.
module tb_regfile_writeback_arbiter;
  localparam int DEPTH = 2;
  localparam int EXP_W = 71;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [EXP_W-1:0] exp_q[$];
  logic [36:0]      mq[$];
  logic             m_we, m_src, m_acc;
  logic [4:0]       m_reg;
  logic [31:0]      m_data, m_pend;
  int               vectors = 0;
  int               miscompares = 0;

  // Reference model: buffered MDU results are a plain queue, pending a bit array.
  always @(posedge clk) begin
    logic [36:0] head;
    m_acc = 1'b0;
    if (reset) begin
      mq.delete();
      m_pend = '0; m_we = 1'b0; m_reg = '0; m_data = '0; m_src = 1'b0;
    end else begin
      m_acc = bus.mdu_valid && (mq.size() < DEPTH);
      if (bus.alu_wb_en && bus.alu_wb_reg != 0) begin
        m_we = 1'b1; m_reg = bus.alu_wb_reg; m_data = bus.alu_wb_data; m_src = 1'b0;
      end else if (mq.size() > 0) begin
        head = mq.pop_front();
        m_we = 1'b1; m_reg = head[36:32]; m_data = head[31:0]; m_src = 1'b1;
        m_pend[head[36:32]] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (m_acc && bus.mdu_reg != 0) mq.push_back({bus.mdu_reg, bus.mdu_data});
      if (bus.issue_en && bus.issue_reg != 0) m_pend[bus.issue_reg] = 1'b1;
    end
    exp_q.push_back({m_we, m_reg, m_data, m_src, m_pend});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("regWrite", 32'(bus.regWrite), 32'(e[70]));
      chk("WriteRegister", 32'(bus.WriteRegister), 32'(e[69:65]));
      chk("WriteData", bus.WriteData, e[64:33]);
      if (e[70]) chk("wb_src", 32'(bus.wb_src), 32'(e[32]));
      chk("pending", bus.pending, e[31:0]);
    end
    chk("mdu_ready", 32'(bus.mdu_ready), 32'(!reset && mq.size() < DEPTH));
  end

  task automatic drive(input logic ae, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic ie, input logic [4:0] ir);
    bus.alu_wb_en = ae; bus.alu_wb_reg = ar; bus.alu_wb_data = ad;
    bus.mdu_valid = mv; bus.mdu_reg = mr; bus.mdu_data = md;
    bus.issue_en = ie; bus.issue_reg = ir;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] b2b[3];
    int idx;
    b2b[0] = 5'd3; b2b[1] = 5'd4; b2b[2] = 5'd5;
    bus.alu_wb_en = 0; bus.alu_wb_reg = 0; bus.alu_wb_data = 0;
    bus.mdu_valid = 0; bus.mdu_reg = 0; bus.mdu_data = 0;
    bus.issue_en = 0; bus.issue_reg = 0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Plain ALU write then idle.
    drive(1, 7, 32'h0000_00AA, 0, 0, 0, 0, 0);
    idle(2);

    // Issue r12, result arrives 5 cycles later.
    drive(0, 0, 0, 0, 0, 0, 1, 12);
    idle(4);
    drive(0, 0, 0, 1, 12, 32'h1234_5678, 0, 0);
    idle(2);

    // ALU busy 6 cycles while MDU offers r3, r4, r5 back-to-back.
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i < 6, 5'(i + 1), 32'hA000_0000 + i, idx < 3, (idx < 3) ? b2b[idx] : 5'd0,
            32'hB000_0000 + idx, 0, 0);
      if (m_acc && idx < 3) idx++;
    end
    idle(2);

    // FIFO holds r9; ALU targets r0 while MDU offers r0.
    drive(1, 2, 32'h22, 1, 9, 32'h9999, 1, 9);
    drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    idle(2);

    // Issue r20 on the edge the earlier r20 result retires.
    drive(0, 0, 0, 0, 0, 0, 1, 20);
    drive(1, 1, 32'h11, 1, 20, 32'h2020, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 20);
    idle(2);

    // Fill FIFO under a busy ALU, then reset mid-operation.
    drive(1, 6, 32'h66, 1, 13, 32'hD13, 1, 13);
    drive(1, 6, 32'h67, 1, 14, 32'hD14, 1, 14);
    drive(1, 6, 32'h68, 1, 15, 32'hD15, 0, 0);
    reset = 1'b1;
    drive(1, 6, 32'h69, 1, 16, 32'hD16, 1, 16);
    reset = 1'b0;
    idle(4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
    end
    reset = 1'b0;
    idle(6);

    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
